// File: rtl/embed_pkg.sv
// Shared types and widths for the embedding token scheduler.
package embed_pkg;
  localparam int CNT_W     = 7;
  localparam int FRAME_W   = 24;
  localparam int OFF_W     = 16;
  localparam int NUM_W     = 12;
  localparam int GAP_W     = 7;
  localparam int PROD_W    = NUM_W + GAP_W;
  localparam int CHUNK_MAX = 64;

  typedef enum logic [2:0] {IDLE, CHECK, OFFSET, EMBED, TAIL, DONE} state_t;

  // Largest chunk of pass-through bits one token may carry.
  function automatic logic [CNT_W-1:0] chunk(input logic [FRAME_W-1:0] left);
    return (left > FRAME_W'(CHUNK_MAX)) ? CNT_W'(CHUNK_MAX) : left[CNT_W-1:0];
  endfunction
endpackage

// File: rtl/embed_sched_if.sv
// Config, token FIFO and status bundle between a controller and embed_sched.
interface embed_sched_if;
  import embed_pkg::*;
  logic               clk_en;
  logic               cfg_start;
  logic [FRAME_W-1:0] cfg_frame_bits;
  logic [OFF_W-1:0]   cfg_offset;
  logic [GAP_W-1:0]   cfg_gap;
  logic [NUM_W-1:0]   cfg_count;
  logic               cfg_extend;
  logic               cfg_abort;
  logic               tok_afull;
  logic [CNT_W-1:0]   tok_cnt;
  logic               tok_sign;
  logic               tok_extend;
  logic               tok_wr;
  logic               busy;
  logic               done;
  logic               cfg_err;

  modport master (
    output clk_en, cfg_start, cfg_frame_bits, cfg_offset, cfg_gap, cfg_count,
           cfg_extend, cfg_abort, tok_afull,
    input  tok_cnt, tok_sign, tok_extend, tok_wr, busy, done, cfg_err
  );
  modport slave (
    input  clk_en, cfg_start, cfg_frame_bits, cfg_offset, cfg_gap, cfg_count,
           cfg_extend, cfg_abort, tok_afull,
    output tok_cnt, tok_sign, tok_extend, tok_wr, busy, done, cfg_err
  );
endinterface

// File: rtl/embed_sched.sv
// Splits a video frame into offset / sign / tail tokens for the bit replacer FIFO.
module embed_sched
  import embed_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  embed_sched_if.slave  bus
);
  state_t             state_q, state_d, ph;
  logic [OFF_W-1:0]   off_q, off_d;
  logic [FRAME_W-1:0] bits_q, bits_d;
  logic [NUM_W-1:0]   num_q, num_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               ext_q, ext_d;
  logic [PROD_W-1:0]  prod_q, prod_d;
  logic               tok_wr_q, tok_wr_d, tok_sign_q, tok_sign_d, tok_ext_q, tok_ext_d;
  logic [CNT_W-1:0]   tok_cnt_q, tok_cnt_d, c;
  logic [FRAME_W:0]   need;
  logic               en, bad;

  assign en = bus.clk_en & ~bus.tok_afull;

  always_comb begin
    state_d    = state_q;
    off_d      = off_q;
    bits_d     = bits_q;
    num_d      = num_q;
    gap_d      = gap_q;
    ext_d      = ext_q;
    prod_d     = prod_q;
    tok_wr_d   = 1'b0;
    tok_cnt_d  = tok_cnt_q;
    tok_sign_d = tok_sign_q;
    tok_ext_d  = tok_ext_q;
    ph         = state_q;
    c          = '0;
    // bits_q still holds the whole frame length while in CHECK
    need = (FRAME_W+1)'(off_q) + (FRAME_W+1)'(prod_q);
    bad  = (gap_q == '0) || (ext_q && gap_q < GAP_W'(2)) || (need > {1'b0, bits_q});
    if (en) begin
      if (state_q == IDLE) begin
        if (bus.cfg_start) begin
          bits_d  = bus.cfg_frame_bits;
          off_d   = bus.cfg_offset;
          gap_d   = bus.cfg_gap;
          num_d   = bus.cfg_count;
          ext_d   = bus.cfg_extend;
          prod_d  = PROD_W'(bus.cfg_count) * PROD_W'(bus.cfg_gap);
          state_d = CHECK;
        end
      end else if (bus.cfg_abort || state_q == DONE || (state_q == CHECK && bad)) begin
        state_d = IDLE;
      end else begin
        // Empty phases fall through so a token goes out every enabled cycle.
        ph = (state_q == CHECK) ? OFFSET : state_q;
        if (ph == OFFSET && off_q == '0) ph = EMBED;
        if (ph == EMBED && num_q == '0)  ph = TAIL;
        if (ph == TAIL && bits_q == '0)  ph = DONE;
        case (ph)
          OFFSET: begin
            c          = chunk(FRAME_W'(off_q));
            tok_wr_d   = 1'b1;
            tok_cnt_d  = c;
            tok_sign_d = 1'b0;
            tok_ext_d  = 1'b0;
            off_d      = off_q - OFF_W'(c);
            bits_d     = bits_q - FRAME_W'(c);
            state_d    = (off_q == OFF_W'(c)) ? EMBED : OFFSET;
          end
          EMBED: begin
            tok_wr_d   = 1'b1;
            tok_cnt_d  = gap_q;
            tok_sign_d = 1'b1;
            tok_ext_d  = ext_q;
            num_d      = num_q - NUM_W'(1);
            bits_d     = bits_q - FRAME_W'(gap_q);
            state_d    = (num_q == NUM_W'(1)) ? TAIL : EMBED;
          end
          TAIL: begin
            c          = chunk(bits_q);
            tok_wr_d   = 1'b1;
            tok_cnt_d  = c;
            tok_sign_d = 1'b0;
            tok_ext_d  = 1'b0;
            bits_d     = bits_q - FRAME_W'(c);
            state_d    = (bits_q == FRAME_W'(c)) ? DONE : TAIL;
          end
          default: state_d = DONE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      off_q      <= '0;
      bits_q     <= '0;
      num_q      <= '0;
      gap_q      <= '0;
      ext_q      <= 1'b0;
      prod_q     <= '0;
      tok_wr_q   <= 1'b0;
      tok_cnt_q  <= '0;
      tok_sign_q <= 1'b0;
      tok_ext_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      off_q      <= off_d;
      bits_q     <= bits_d;
      num_q      <= num_d;
      gap_q      <= gap_d;
      ext_q      <= ext_d;
      prod_q     <= prod_d;
      tok_wr_q   <= tok_wr_d;
      tok_cnt_q  <= tok_cnt_d;
      tok_sign_q <= tok_sign_d;
      tok_ext_q  <= tok_ext_d;
    end
  end

  assign bus.tok_wr     = tok_wr_q;
  assign bus.tok_cnt    = tok_cnt_q;
  assign bus.tok_sign   = tok_sign_q;
  assign bus.tok_extend = tok_ext_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);
  assign bus.cfg_err    = (state_q == CHECK) && bad;
endmodule

// File: tb/tb_embed_sched.sv
// Directed bench for embed_sched: token sequences, config errors, stalls, abort, reset.
module tb_embed_sched;
  import embed_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  embed_sched_if bus();
  embed_sched dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int n_cmp = 0, n_bad = 0;
  int n_done = 0, n_err = 0, seen = 0;
  logic [8:0] got[$];
  logic [8:0] exp_q[$];

  always @(negedge clk) begin
    if (bus.tok_wr === 1'b1) got.push_back({bus.tok_cnt, bus.tok_sign, bus.tok_extend});
    if (bus.done === 1'b1) n_done++;
    if (bus.cfg_err === 1'b1) n_err++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // tick that also counts tokens visible after the edge
  task automatic tk(input int n = 1);
    repeat (n) begin
      tick();
      if (bus.tok_wr === 1'b1) seen++;
    end
  endtask

  task automatic run_until(input string tag, input int n);
    for (int i = 0; i < 300 && seen < n; i++) tk();
    chk(tag, seen, n);
  endtask

  task automatic set_cfg(input logic [23:0] fr, input logic [15:0] off,
                         input logic [6:0] gap, input logic [11:0] cnt, input logic ext);
    bus.cfg_frame_bits = fr;
    bus.cfg_offset     = off;
    bus.cfg_gap        = gap;
    bus.cfg_count      = cnt;
    bus.cfg_extend     = ext;
  endtask

  task automatic start();
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    seen = 0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 400 && bus.done !== 1'b1; i++) tick();
    chk(tag, bus.done, 1);
    tick();
  endtask

  task automatic push(input logic [6:0] cnt, input logic sg, input logic ex, input int n);
    repeat (n) exp_q.push_back({cnt, sg, ex});
  endtask

  task automatic chk_seq(input string tag, input int base);
    chk({tag, "_len"}, got.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && base + i < got.size(); i++)
      chk(tag, got[base+i], exp_q[i]);
    exp_q.delete();
  endtask

  task automatic push_frame_a();
    push(7'd10, 1'b0, 1'b0, 1);
    push(7'd8,  1'b1, 1'b0, 4);
    push(7'd64, 1'b0, 1'b0, 3);
    push(7'd22, 1'b0, 1'b0, 1);
  endtask

  initial begin
    int base, db, eb;
    rst = 1'b1;
    bus.clk_en = 1'b1; bus.cfg_start = 1'b0; bus.cfg_abort = 1'b0; bus.tok_afull = 1'b0;
    set_cfg(24'd0, 16'd0, 7'd0, 12'd0, 1'b0);
    tick(3);
    chk("rst_tok_wr", bus.tok_wr, 0);
    chk("rst_tok_cnt", bus.tok_cnt, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_cfg_err", bus.cfg_err, 0);
    rst = 1'b0;
    tick();

    // basic frame with latency check
    base = got.size(); db = n_done;
    set_cfg(24'd256, 16'd10, 7'd8, 12'd4, 1'b0);
    start();
    chk("a_check_busy", bus.busy, 1);
    chk("a_check_wr", bus.tok_wr, 0);
    tick();
    chk("a_first_wr", bus.tok_wr, 1);
    chk("a_first_cnt", bus.tok_cnt, 10);
    wait_done("a_done");
    chk("a_idle", bus.busy, 0);
    chk("a_done_cnt", n_done - db, 1);
    push_frame_a();
    chk_seq("a_tok", base);

    // config error: offset + count*gap exceeds frame
    base = got.size(); eb = n_err;
    set_cfg(24'd256, 16'd200, 7'd8, 12'd10, 1'b0);
    start();
    chk("b_err_t1", bus.cfg_err, 1);
    tick();
    chk("b_busy_t2", bus.busy, 0);
    chk("b_err_t2", bus.cfg_err, 0);
    tick(5);
    chk("b_no_tok", got.size() - base, 0);
    chk("b_err_pulses", n_err - eb, 1);

    // stall after the 2nd sign token
    base = got.size();
    set_cfg(24'd256, 16'd10, 7'd8, 12'd4, 1'b0);
    start();
    run_until("c_reach", 3);
    bus.tok_afull = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("c_stall_wr", bus.tok_wr, 0);
    end
    bus.tok_afull = 1'b0;
    wait_done("c_done");
    push_frame_a();
    chk_seq("c_tok", base);

    // no offset, no sign bits
    base = got.size();
    set_cfg(24'd128, 16'd0, 7'd8, 12'd0, 1'b0);
    start();
    wait_done("d_done");
    push(7'd64, 1'b0, 1'b0, 2);
    chk_seq("d_tok", base);

    // extend with gap 1 is illegal
    base = got.size(); eb = n_err;
    set_cfg(24'd64, 16'd0, 7'd1, 12'd2, 1'b1);
    start();
    tick(4);
    chk("e1_err", n_err - eb, 1);
    chk("e1_no_tok", got.size() - base, 0);

    // extend with gap 4
    base = got.size();
    set_cfg(24'd16, 16'd0, 7'd4, 12'd2, 1'b1);
    start();
    wait_done("e2_done");
    push(7'd4, 1'b1, 1'b1, 2);
    push(7'd8, 1'b0, 1'b0, 1);
    chk_seq("e2_tok", base);

    // start while busy ignored, then abort in TAIL
    base = got.size(); db = n_done;
    set_cfg(24'd256, 16'd10, 7'd8, 12'd4, 1'b0);
    start();
    run_until("f_reach1", 2);
    set_cfg(24'd100, 16'd0, 7'd5, 12'd1, 1'b1);
    bus.cfg_start = 1'b1;
    tk();
    bus.cfg_start = 1'b0;
    run_until("f_reach2", 6);
    bus.cfg_abort = 1'b1;
    tk();
    bus.cfg_abort = 1'b0;
    chk("f_abort_wr", bus.tok_wr, 0);
    chk("f_abort_busy", bus.busy, 0);
    tk(10);
    chk("f_seen", seen, 6);
    chk("f_no_done", n_done - db, 0);
    push(7'd10, 1'b0, 1'b0, 1);
    push(7'd8,  1'b1, 1'b0, 4);
    push(7'd64, 1'b0, 1'b0, 1);
    chk_seq("f_tok", base);

    // reset mid-frame
    set_cfg(24'd256, 16'd10, 7'd8, 12'd4, 1'b0);
    start();
    run_until("g_reach", 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("g_rst_wr", bus.tok_wr, 0);
    chk("g_rst_cnt", bus.tok_cnt, 0);
    chk("g_rst_busy", bus.busy, 0);
    tk(10);
    chk("g_seen", seen, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
